// File: rtl/point_memory_axi_responder.sv
// point_memory_axi_responder
//   AXI4-Lite read-only responder in front of a small word-addressed point
//   memory. The memory is loaded through a simple side write port. Exactly one
//   read is outstanding at a time, and each read is answered a fixed
//   RESP_DELAY cycles after its AR handshake. The hold input freezes the
//   address acceptance and the delay countdown. This lets an initiator's
//   timeout logic be exercised.
//
// Ports
//   aclk, aresetn           clock, asynchronous active-low reset
//   load_en/index/data      memory write port, accepted in every state
//   hold                    stalls AR acceptance and the response countdown
//   s_ar*                   AXI read-address channel (arprot is ignored)
//   s_r*                    AXI read-data channel
//   err_count               saturating count of non-OKAY R handshakes

package ransac;
   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_value_e;
endpackage

module point_memory_axi_responder #(
   parameter  int DATA_WIDTH  = 32,
   parameter  int ADDR_WIDTH  = 16,
   parameter  int DEPTH_WORDS = 1024,
   parameter  int RESP_DELAY  = 2,
   localparam int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        load_en,
   input  logic [IDX_W-1:0]            load_index,
   input  logic [DATA_WIDTH-1:0]       load_data,
   input  logic                        hold,
   input  logic                        s_arvalid,
   output logic                        s_arready,
   input  logic [ADDR_WIDTH-1:0]       s_araddr,
   input  logic [2:0]                  s_arprot,
   output logic                        s_rvalid,
   input  logic                        s_rready,
   output logic [DATA_WIDTH-1:0]       s_rdata,
   output ransac::axi_resp_value_e     s_rresp,
   output logic [15:0]                 err_count
);

   typedef enum logic [1:0] {IDLE, DELAY, RESP} state_e;

   state_e                  state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   ransac::axi_resp_value_e rresp_q, rresp_d;
   logic [15:0]             err_q, err_d;
   logic                    do_read;

   // Memory has no reset so its contents survive an aresetn pulse.
   logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

   // Protection bits carry no meaning for this responder.
   logic unused_arprot;
   assign unused_arprot = ^s_arprot;

   // With RESP_DELAY=1 the read happens in the handshake cycle itself.
   // In that case the live address is decoded instead of the captured one.
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic [ADDR_WIDTH-3:0]   rd_word;
   logic                    rd_misalign, rd_oor;

   assign rd_addr     = (state_q == IDLE) ? s_araddr : addr_q;
   assign rd_word     = rd_addr[ADDR_WIDTH-1:2];
   assign rd_misalign = |rd_addr[1:0];
   assign rd_oor      = 32'(rd_word) >= 32'(DEPTH_WORDS);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      err_d     = err_q;
      do_read   = 1'b0;
      s_arready = 1'b0;

      case (state_q)
         IDLE: begin
            s_arready = !hold && aresetn;
            if (s_arvalid && !hold) begin
               addr_d = s_araddr;
               cnt_d  = 8'(RESP_DELAY - 1);
               if (RESP_DELAY == 1) do_read = 1'b1;
               else                 state_d = DELAY;
            end
         end
         DELAY: begin
            // The read fires on the decrement that brings the counter to
            // zero. RVALID therefore lands RESP_DELAY cycles after the
            // handshake. Any cycle with hold asserted pushes it out by one.
            if (!hold) begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) do_read = 1'b1;
            end
         end
         RESP: begin
            if (s_rready) begin
               rvalid_d = 1'b0;
               state_d  = IDLE;
               if (rresp_q != ransac::OKAY && err_q != 16'hFFFF)
                  err_d = err_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (do_read) begin
         state_d  = RESP;
         rvalid_d = 1'b1;
         if (rd_misalign) begin
            rresp_d = ransac::SLVERR;
            rdata_d = '0;
         end else if (rd_oor) begin
            rresp_d = ransac::DECERR;
            rdata_d = '0;
         end else begin
            rresp_d = ransac::OKAY;
            // Combinational read of the current contents. A write at the
            // same edge lands afterwards, so the read returns the old data.
            rdata_d = mem[rd_word[IDX_W-1:0]];
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= ransac::OKAY;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
         err_q    <= err_d;
      end
   end

   always_ff @(posedge aclk) begin
      if (load_en) mem[load_index] <= load_data;
   end

   assign s_rvalid  = rvalid_q;
   assign s_rdata   = rdata_q;
   assign s_rresp   = rresp_q;
   assign err_count = err_q;

endmodule
